// File: rtl/seq_pattern_detector.sv
// -----------------------------------------------------------------------------
// seq_pattern_detector
//
// Serial bit-pattern detector. Finds a PATTERN_LEN-bit pattern, first bit =
// PATTERN[PATTERN_LEN-1], in a qualified serial stream. Typically sits behind a
// serial receiver / framer as a sync-word or flag detector.
//
// Parameters
//   PATTERN_LEN  pattern length in bits (2..16)
//   PATTERN      pattern value, MSB is received first
//   OVERLAP      1: a match may reuse its own tail as the start of the next one
//                0: after a match the search restarts from scratch
//   MEALY        1: match is combinational in the cycle of the completing bit
//                0: match is registered, high the cycle after the completing bit
//   MATCH_CNT_W  width of the optional saturating match counter
//
// Optional feature
//   SEQ_DET_MATCH_CNT_EN  when defined, adds the match_count output and a
//                         saturating counter of match events (cleared by rst
//                         only). When undefined there is no counter and no port.
//
// Ports
//   clk          clock, all state changes on the rising edge
//   rst          synchronous reset, active low
//   in_valid     qualifies in_bit
//   in_bit       serial data bit
//   clear        synchronous flush of the matched-prefix state
//   match        pattern-complete pulse (timing chosen by MEALY)
//   progress     matched-prefix length, 0..PATTERN_LEN-1 (the FSM state)
//   match_count  saturating match total (only with SEQ_DET_MATCH_CNT_EN)
//
// Handshake: the input side is valid-only. A bit is consumed on every rising
// edge where rst=1, clear=0 and in_valid=1; there is no back-pressure, and any
// number of in_valid=0 cycles between bits is invisible to the detector.
// Priority is rst > clear > in_valid.
// -----------------------------------------------------------------------------
module seq_pattern_detector #(
  parameter int                     PATTERN_LEN = 4,
  parameter logic [PATTERN_LEN-1:0] PATTERN     = 4'b1011,
  parameter bit                     OVERLAP     = 1'b0,
  parameter bit                     MEALY       = 1'b1,
  parameter int                     MATCH_CNT_W = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  input  logic                           in_bit,
  input  logic                           clear,
  output logic                           match,
  output logic [$clog2(PATTERN_LEN)-1:0] progress
`ifdef SEQ_DET_MATCH_CNT_EN
  ,
  output logic [MATCH_CNT_W-1:0]         match_count
`endif
);

  localparam int PW = $clog2(PATTERN_LEN);
  localparam logic [PW-1:0] LAST = PW'(PATTERN_LEN - 1);

  // Elaboration-time parameter sanity checks.
  if (PATTERN_LEN < 2 || PATTERN_LEN > 16) begin : g_bad_len
    $error("seq_pattern_detector: PATTERN_LEN must be in 2..16");
  end
  if (MATCH_CNT_W < 1) begin : g_bad_cnt_w
    $error("seq_pattern_detector: MATCH_CNT_W must be at least 1");
  end

  // ---------------------------------------------------------------------------
  // Constant functions building the KMP transition table.
  // Pattern bit i is the i-th bit received, i.e. PATTERN[PATTERN_LEN-1-i].
  // A shift is used instead of a variable bit-select so the index stays clean.
  // ---------------------------------------------------------------------------
  function automatic logic pat_bit(input int i);
    logic [PATTERN_LEN-1:0] v;
    v = PATTERN >> (PATTERN_LEN - 1 - i);
    return v[0];
  endfunction

  // Longest prefix length l (1..max_len) of the pattern that equals the tail of
  // the string "first k pattern bits followed by b". Zero if none fits.
  function automatic int longest_fit(input int k, input logic b, input int max_len);
    int   best;
    int   idx;
    logic ok;
    logic s_bit;
    best = 0;
    for (int l = 1; l <= max_len; l++) begin
      ok = 1'b1;
      for (int j = 0; j < l; j++) begin
        idx   = k + 1 - l + j;
        s_bit = (idx == k) ? b : pat_bit(idx);
        if (s_bit != pat_bit(j)) ok = 1'b0;
      end
      if (ok) best = l;
    end
    return best;
  endfunction

  // Next matched-prefix length from state k on input bit b.
  function automatic int next_state(input int k, input logic b);
    int nk;
    if (k == PATTERN_LEN - 1 && b == pat_bit(k)) begin
      // Completed match: either resume from the longest proper border of the
      // whole pattern (overlapping) or start over.
      nk = OVERLAP ? longest_fit(k, b, PATTERN_LEN - 1) : 0;
    end else begin
      // Either extend the prefix (k+1) or fall back to the longest prefix
      // that still ends the sequence seen so far.
      nk = longest_fit(k, b, (k + 1 < PATTERN_LEN) ? k + 1 : PATTERN_LEN - 1);
    end
    return nk;
  endfunction

  // Transition table, one constant entry per state and input bit.
  logic [PW-1:0] next_on_0 [PATTERN_LEN];
  logic [PW-1:0] next_on_1 [PATTERN_LEN];

  for (genvar k = 0; k < PATTERN_LEN; k++) begin : g_next
    localparam int N0 = next_state(k, 1'b0);
    localparam int N1 = next_state(k, 1'b1);
    assign next_on_0[k] = PW'(N0);
    assign next_on_1[k] = PW'(N1);
  end

  // ---------------------------------------------------------------------------
  // FSM: the state is the matched-prefix length.
  // ---------------------------------------------------------------------------
  logic [PW-1:0] state_q;
  logic [PW-1:0] state_d;
  logic          hit;      // a match event in this cycle (sampled completing bit)

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= '0;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hit     = 1'b0;
    if (clear) begin
      state_d = '0;
    end else if (in_valid) begin
      state_d = in_bit ? next_on_1[state_q] : next_on_0[state_q];
      hit     = (state_q == LAST) && (in_bit == PATTERN[0]);
    end
  end

  assign progress = state_q;

  // ---------------------------------------------------------------------------
  // Match output style.
  // ---------------------------------------------------------------------------
  if (MEALY) begin : g_mealy
    assign match = hit;
  end else begin : g_moore
    logic match_q;
    // hit is already 0 under clear or in_valid=0, so those cycles drop match.
    always_ff @(posedge clk) begin
      if (!rst) begin
        match_q <= 1'b0;
      end else begin
        match_q <= hit;
      end
    end
    assign match = match_q;
  end

`ifdef SEQ_DET_MATCH_CNT_EN
  // ---------------------------------------------------------------------------
  // Saturating match counter; clear does not touch it, only rst does.
  // ---------------------------------------------------------------------------
  logic [MATCH_CNT_W-1:0] count_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= '0;
    end else if (hit && (count_q != {MATCH_CNT_W{1'b1}})) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign match_count = count_q;
`endif

endmodule

// File: tb/tb_seq_pattern_detector.sv
// -----------------------------------------------------------------------------
// tb_seq_pattern_detector
//
// Five detector instances share one input stream:
//   d0: 1011, OVERLAP=0, MEALY=1      d1: 1011, OVERLAP=0, MEALY=0
//   d2: 1011, OVERLAP=1, MEALY=1      d3: 1011, OVERLAP=1, MEALY=0
//   d4: 10101, OVERLAP=1, MEALY=0
// Each is tracked by a shift-register reference model: the accepted bits since
// the last restart, with match = "last LEN bits equal the pattern" and
// progress = "longest proper pattern prefix ending the history".
// -----------------------------------------------------------------------------
module tb_seq_pattern_detector;

  localparam int NDUT = 5;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk;
  logic rst;
  logic in_valid;
  logic in_bit;
  logic clear;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------------------------------------------------------------------
  // DUTs
  // ---------------------------------------------------------------------------
  logic [NDUT-1:0] match_v;
  logic [1:0]      prog0, prog1, prog2, prog3;
  logic [2:0]      prog4;
  logic [31:0]     dut_prog [NDUT];

  assign dut_prog[0] = 32'(prog0);
  assign dut_prog[1] = 32'(prog1);
  assign dut_prog[2] = 32'(prog2);
  assign dut_prog[3] = 32'(prog3);
  assign dut_prog[4] = 32'(prog4);

`ifdef SEQ_DET_MATCH_CNT_EN
  logic [7:0]  cnt0, cnt1, cnt3, cnt4;
  logic [1:0]  cnt2;
  logic [31:0] dut_cnt [NDUT];
  assign dut_cnt[0] = 32'(cnt0);
  assign dut_cnt[1] = 32'(cnt1);
  assign dut_cnt[2] = 32'(cnt2);
  assign dut_cnt[3] = 32'(cnt3);
  assign dut_cnt[4] = 32'(cnt4);
`endif

  seq_pattern_detector #(.PATTERN_LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b0), .MEALY(1'b1), .MATCH_CNT_W(8)) u_d0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit), .clear(clear),
    .match(match_v[0]), .progress(prog0)
`ifdef SEQ_DET_MATCH_CNT_EN
    , .match_count(cnt0)
`endif
  );

  seq_pattern_detector #(.PATTERN_LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b0), .MEALY(1'b0), .MATCH_CNT_W(8)) u_d1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit), .clear(clear),
    .match(match_v[1]), .progress(prog1)
`ifdef SEQ_DET_MATCH_CNT_EN
    , .match_count(cnt1)
`endif
  );

  seq_pattern_detector #(.PATTERN_LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .MEALY(1'b1), .MATCH_CNT_W(2)) u_d2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit), .clear(clear),
    .match(match_v[2]), .progress(prog2)
`ifdef SEQ_DET_MATCH_CNT_EN
    , .match_count(cnt2)
`endif
  );

  seq_pattern_detector #(.PATTERN_LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .MEALY(1'b0), .MATCH_CNT_W(8)) u_d3 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit), .clear(clear),
    .match(match_v[3]), .progress(prog3)
`ifdef SEQ_DET_MATCH_CNT_EN
    , .match_count(cnt3)
`endif
  );

  seq_pattern_detector #(.PATTERN_LEN(5), .PATTERN(5'b10101), .OVERLAP(1'b1), .MEALY(1'b0), .MATCH_CNT_W(8)) u_d4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit), .clear(clear),
    .match(match_v[4]), .progress(prog4)
`ifdef SEQ_DET_MATCH_CNT_EN
    , .match_count(cnt4)
`endif
  );

  // ---------------------------------------------------------------------------
  // Scoreboard counters and checker
  // ---------------------------------------------------------------------------
  int n_tests = 0;
  int n_fail  = 0;
  int seen [NDUT];   // match pulses observed since the last seen-reset

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model (shift-register history of accepted bits)
  // ---------------------------------------------------------------------------
  int          m_len   [NDUT];
  logic [15:0] m_pat   [NDUT];
  bit          m_ovl   [NDUT];
  bit          m_mealy [NDUT];
  int          m_cmax  [NDUT];
  logic [31:0] m_sh    [NDUT];
  int          m_n     [NDUT];   // number of valid history bits
  bit          m_mq    [NDUT];   // expected registered match
  int          m_cnt   [NDUT];

  task automatic model_init();
    for (int d = 0; d < NDUT; d++) begin
      m_len[d]  = 4;
      m_pat[d]  = 16'b1011;
      m_cmax[d] = 255;
      m_sh[d]   = '0;
      m_n[d]    = 0;
      m_mq[d]   = 1'b0;
      m_cnt[d]  = 0;
      seen[d]   = 0;
    end
    m_ovl[0] = 1'b0; m_mealy[0] = 1'b1;
    m_ovl[1] = 1'b0; m_mealy[1] = 1'b0;
    m_ovl[2] = 1'b1; m_mealy[2] = 1'b1; m_cmax[2] = 3;
    m_ovl[3] = 1'b1; m_mealy[3] = 1'b0;
    m_ovl[4] = 1'b1; m_mealy[4] = 1'b0; m_len[4] = 5; m_pat[4] = 16'b10101;
  endtask

  // True when the last l history bits equal the first l pattern bits.
  function automatic bit suffix_ok(input logic [31:0] sh, input int n, input int len,
                                   input logic [15:0] pat, input int l);
    logic [31:0] mask;
    logic [31:0] want;
    if (l > n) return 1'b0;
    if (l == 0) return 1'b1;
    mask = (32'd1 << l) - 32'd1;
    want = {16'd0, pat} >> (len - l);
    return (sh & mask) == want;
  endfunction

  function automatic int model_prog(input int d);
    for (int l = m_len[d] - 1; l > 0; l--) begin
      if (suffix_ok(m_sh[d], m_n[d], m_len[d], m_pat[d], l)) return l;
    end
    return 0;
  endfunction

  // Would accepting bit b now complete the pattern?
  function automatic bit would_match(input int d, input logic b);
    logic [31:0] t;
    t = {m_sh[d][30:0], b};
    return suffix_ok(t, m_n[d] + 1, m_len[d], m_pat[d], m_len[d]);
  endfunction

  task automatic model_update(input int d, input logic r, input logic v, input logic b, input logic c);
    bit h;
    if (!r) begin
      m_sh[d] = '0; m_n[d] = 0; m_mq[d] = 1'b0; m_cnt[d] = 0;
    end else if (c) begin
      m_n[d] = 0; m_mq[d] = 1'b0;
    end else if (v) begin
      h = would_match(d, b);
      m_sh[d] = {m_sh[d][30:0], b};
      if (m_n[d] < 32) m_n[d]++;
      m_mq[d] = h;
      if (h) begin
        if (m_cnt[d] < m_cmax[d]) m_cnt[d]++;
        if (!m_ovl[d]) m_n[d] = 0;
      end
    end else begin
      m_mq[d] = 1'b0;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver: one clock per call, entered and left at a falling edge.
  // Outputs are checked 1 time unit after the inputs are driven.
  // ---------------------------------------------------------------------------
  task automatic step(input logic r, input logic v, input logic b, input logic c);
    logic exp_m;
    rst = r; in_valid = v; in_bit = b; clear = c;
    #1;
    for (int d = 0; d < NDUT; d++) begin
      exp_m = m_mealy[d] ? (v && !c && would_match(d, b)) : m_mq[d];
      check_eq($sformatf("d%0d_match", d), 32'(match_v[d]), 32'(exp_m));
      check_eq($sformatf("d%0d_progress", d), dut_prog[d], 32'(model_prog(d)));
`ifdef SEQ_DET_MATCH_CNT_EN
      check_eq($sformatf("d%0d_count", d), dut_cnt[d], 32'(m_cnt[d]));
`endif
      if (match_v[d] === 1'b1) seen[d]++;
    end
    @(posedge clk);
    for (int d = 0; d < NDUT; d++) model_update(d, r, v, b, c);
    @(negedge clk);
  endtask

  task automatic send_bits(input string bits);
    for (int i = 0; i < bits.len(); i++) step(1'b1, 1'b1, bits[i] == 8'h31, 1'b0);
  endtask

  task automatic idle();
    step(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic flush();
    step(1'b1, 1'b0, 1'b0, 1'b1);
    for (int d = 0; d < NDUT; d++) seen[d] = 0;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic r, v, b, c;
    rst = 1'b0; in_valid = 1'b0; in_bit = 1'b0; clear = 1'b0;
    model_init();
    repeat (2) @(posedge clk);
    @(negedge clk);

    // Reset state, held in reset for two checked cycles.
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);

    // Non-overlapping vs overlapping on 1011011.
    flush();
    send_bits("1011011");
    idle();
    check_eq("t1_nonovl_mealy_matches", seen[0], 1);
    check_eq("t1_nonovl_moore_matches", seen[1], 1);
    check_eq("t1_nonovl_progress", dut_prog[0], 1);
    check_eq("t2_ovl_mealy_matches", seen[2], 2);
    check_eq("t2_ovl_moore_matches", seen[3], 2);

    // KMP fallback 3 -> 2 on 101011.
    flush();
    send_bits("1010");
    check_eq("t3_fallback_progress", dut_prog[2], 2);
    send_bits("11");
    idle();
    check_eq("t3_ovl_matches", seen[2], 1);

    // Moore timing with a 3-cycle stall between bits 2 and 3.
    flush();
    send_bits("10");
    repeat (3) idle();
    send_bits("11");
    check_eq("t4_moore_next_cycle", 32'(match_v[1]), 1);
    idle();
    check_eq("t4_moore_one_cycle", 32'(match_v[1]), 0);
    check_eq("t4_moore_matches", seen[1], 1);

    // Reset mid-pattern, then clear on the completing bit.
    flush();
    send_bits("101");
    step(1'b0, 1'b0, 1'b0, 1'b0);
    send_bits("1");
    idle();
    check_eq("t5_rst_no_match", seen[0] + seen[1] + seen[2] + seen[3], 0);
    check_eq("t5_rst_progress", dut_prog[0], 1);
    flush();
    send_bits("101");
    step(1'b1, 1'b1, 1'b1, 1'b1);
    idle();
    check_eq("t5_clear_no_match", seen[0] + seen[1] + seen[2] + seen[3], 0);
    check_eq("t5_clear_progress", dut_prog[2], 0);

`ifdef SEQ_DET_MATCH_CNT_EN
    // Saturating counter (2 bits) on overlapping stream with 4 matches.
    step(1'b0, 1'b0, 1'b0, 1'b0);
    for (int d = 0; d < NDUT; d++) seen[d] = 0;
    send_bits("1011011011011");
    idle();
    check_eq("t6_matches", seen[2], 4);
    check_eq("t6_count_sat", dut_cnt[2], 3);
    flush();
    check_eq("t6_count_held", dut_cnt[2], 3);
`endif

    // Randomized stream against the model.
    for (int i = 0; i < 1000; i++) begin
      r = ($urandom_range(0, 199) != 0);
      c = ($urandom_range(0, 49) == 0);
      v = r && ($urandom_range(0, 9) < 8);
      b = 1'($urandom_range(0, 1));
      step(r, v, b, c);
    end
    idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
